// File: rtl/axivideo_gen.sv
// axivideo_gen: AXI4-Stream video frame source with test patterns and backpressure.
// Define AXIVIDEO_GEN_FRAMEIDX_EN to add the frame-index counter behind pattern 3.
module axivideo_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_GAP  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [15:0]           hsize,
  input  logic [15:0]           vsize,
  input  logic [1:0]            pattern,
  output logic                  m_axis_video_tuser,
  output logic                  m_axis_video_tlast,
  output logic                  m_axis_video_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
  input  logic                  m_axis_video_tready,
  output logic                  busy,
  output logic                  frame_done
);
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_e;
  localparam logic [15:0] GAP_LAST = 16'(FRAME_GAP > 0 ? FRAME_GAP - 1 : 0);
  state_e state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d, hs_q, hs_d, vs_q, vs_d, gap_q, gap_d, fidx_d;
  logic [1:0] pat_q, pat_d;
  logic tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d, done_q, busy_q;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic go, acc, eol, fin, load;
  assign go  = enable && hsize != 16'd0 && vsize != 16'd0;
  assign acc = tvalid_q && m_axis_video_tready;
  assign eol = x_q == hs_q - 16'd1;
  assign fin = state_q == RUN && acc && eol && y_q == vs_q - 16'd1;
`ifdef AXIVIDEO_GEN_FRAMEIDX_EN
  localparam bit FIDX_EN = 1'b1;
  logic [15:0] fidx_q;
  assign fidx_d = fidx_q + 16'(fin);
  always_ff @(posedge clk) fidx_q <= !rst_n ? 16'd0 : fidx_d;
`else
  localparam bit FIDX_EN = 1'b0;
  assign fidx_d = 16'd0;
`endif
  function automatic logic [DATA_WIDTH-1:0] pix(input logic [1:0] p, input logic [15:0] px,
                                                input logic [15:0] py, input logic [15:0] fi);
    return p == 2'd1 ? DATA_WIDTH'(py) :
           p == 2'd2 ? {DATA_WIDTH{px[3] ^ py[3]}} :
           (p == 2'd3 && FIDX_EN) ? DATA_WIDTH'(fi) : DATA_WIDTH'(px);
  endfunction
  // Output registers are loaded from the next-state coordinates, so a stalled beat holds naturally.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    pat_d    = pat_q;
    gap_d    = gap_q;
    tvalid_d = tvalid_q;
    load     = 1'b0;
    if (state_q == IDLE) begin
      load    = go;
      state_d = go ? RUN : IDLE;
    end else if (state_q == RUN) begin
      if (!tvalid_q) tvalid_d = 1'b1;
      else if (fin) begin
        gap_d    = 16'd0;
        load     = FRAME_GAP == 0 && go;
        tvalid_d = load;
        state_d  = FRAME_GAP > 0 ? GAP : go ? RUN : IDLE;
      end else if (acc) begin
        x_d = eol ? 16'd0 : x_q + 16'd1;
        y_d = eol ? y_q + 16'd1 : y_q;
      end
    end else if (gap_q == GAP_LAST) begin
      load     = go;
      tvalid_d = go;
      state_d  = go ? RUN : IDLE;
    end else gap_d = gap_q + 16'd1;
    if (load) begin
      hs_d  = hsize;
      vs_d  = vsize;
      pat_d = pattern;
      x_d   = 16'd0;
      y_d   = 16'd0;
    end
    tuser_d = tvalid_d && x_d == 16'd0 && y_d == 16'd0;
    tlast_d = tvalid_d && x_d == hs_d - 16'd1;
    tdata_d = tvalid_d ? pix(pat_d, x_d, y_d, fidx_d) : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      hs_q     <= '0;
      vs_q     <= '0;
      pat_q    <= '0;
      gap_q    <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      pat_q    <= pat_d;
      gap_q    <= gap_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      busy_q   <= state_d != IDLE;
      done_q   <= fin;
    end
  end
  assign m_axis_video_tvalid = tvalid_q;
  assign m_axis_video_tuser  = tuser_q;
  assign m_axis_video_tlast  = tlast_q;
  assign m_axis_video_tdata  = tdata_q;
  assign busy                = busy_q;
  assign frame_done          = done_q;
endmodule

// File: tb/tb_axivideo_gen.sv
// tb_axivideo_gen: scoreboard bench for axivideo_gen; one instance without and one with a frame gap.
`timescale 1ns/1ps
module tb_axivideo_gen;
  localparam int DW = 8;
`ifdef AXIVIDEO_GEN_FRAMEIDX_EN
  localparam bit FIDX = 1'b1;
`else
  localparam bit FIDX = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, en0 = 1'b0, en5 = 1'b0, tready = 1'b1;
  logic [15:0] hsize = 16'd0, vsize = 16'd0;
  logic [1:0] pattern = 2'd0;
  logic tuser0, tlast0, tvalid0, busy0, done0, tuser5, tlast5, tvalid5, busy5, done5;
  logic [DW-1:0] tdata0, tdata5;
  logic [DW+1:0] exp_q[$];
  logic [15:0] exp_fidx = 16'd0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  axivideo_gen #(.DATA_WIDTH(DW), .FRAME_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .hsize(hsize), .vsize(vsize), .pattern(pattern),
    .m_axis_video_tuser(tuser0), .m_axis_video_tlast(tlast0), .m_axis_video_tvalid(tvalid0),
    .m_axis_video_tdata(tdata0), .m_axis_video_tready(tready), .busy(busy0), .frame_done(done0));

  axivideo_gen #(.DATA_WIDTH(DW), .FRAME_GAP(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .enable(en5), .hsize(hsize), .vsize(vsize), .pattern(pattern),
    .m_axis_video_tuser(tuser5), .m_axis_video_tlast(tlast5), .m_axis_video_tvalid(tvalid5),
    .m_axis_video_tdata(tdata5), .m_axis_video_tready(tready), .busy(busy5), .frame_done(done5));

  task automatic push_frame(input int h, input int v, input logic [1:0] p);
    for (int y = 0; y < v; y++)
      for (int x = 0; x < h; x++) begin
        logic [15:0] xx, yy;
        logic [DW-1:0] d;
        xx = 16'(x);
        yy = 16'(y);
        d = p == 2'd1 ? yy[DW-1:0] : p == 2'd2 ? {DW{xx[3] ^ yy[3]}} :
            (p == 2'd3 && FIDX) ? exp_fidx[DW-1:0] : xx[DW-1:0];
        exp_q.push_back({x == 0 && y == 0, x == h - 1, d});
      end
    exp_fidx++;
  endtask

  task automatic monitor();
    logic [DW+1:0] e, got, held;
    bit stall;
    stall = 0;
    held = '0;
    forever begin
      @(negedge clk);
      got = {tuser0, tlast0, tdata0};
      if (rst_n !== 1'b1) stall = 0;
      else begin
        if (stall) begin
          n_chk++;
          if (tvalid0 !== 1'b1 || got !== held) begin
            n_fail++;
            $display("FAIL stall_hold t=%0t: got valid=%b beat=%h required valid=1 beat=%h", $time, tvalid0, got, held);
          end
        end
        if (tvalid0 === 1'b1 && tready === 1'b1) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_extra t=%0t: got beat=%h required no beat", $time, got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              n_fail++;
              $display("FAIL beat t=%0t: got {tuser,tlast,tdata}=%h required %h", $time, got, e);
            end
          end
        end
        stall = tvalid0 === 1'b1 && tready !== 1'b1;
        held = got;
      end
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
  endtask

  task automatic pulse_en0();
    @(posedge clk); #1 en0 = 1'b1;
    @(posedge clk); #1 en0 = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    exp_fidx = 16'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_chk++;
    if ({tvalid0, tuser0, tlast0, tdata0, busy0, done0} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut0: got v=%b u=%b l=%b d=%h busy=%b done=%b required all 0", tvalid0, tuser0, tlast0, tdata0, busy0, done0);
    end
    n_chk++;
    if ({tvalid5, tuser5, tlast5, tdata5, busy5, done5} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut5: got v=%b u=%b l=%b d=%h busy=%b done=%b required all 0", tvalid5, tuser5, tlast5, tdata5, busy5, done5);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk); #1;
    n_chk++;
    if (tvalid0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b required 0 0", tvalid0, busy0);
    end
  endtask

  task automatic test_basic();
    bit ok;
    hsize = 16'd4; vsize = 16'd2; pattern = 2'd0; tready = 1'b1;
    push_frame(4, 2, 2'd0);
    @(posedge clk); #1 en0 = 1'b1;
    @(posedge clk); #1 en0 = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (tvalid0 !== 1'b0 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency_n: got valid=%b busy=%b required 0 1", tvalid0, busy0);
    end
    @(negedge clk); #1;
    n_chk++;
    if (tvalid0 !== 1'b1 || tuser0 !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency_n1: got valid=%b tuser=%b required 1 1", tvalid0, tuser0);
    end
    wait_drain(40, ok);
    n_chk++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_drain: got %0d beats pending required 0", exp_q.size()); end
    @(posedge clk); @(negedge clk); #1;
    n_chk++;
    if (done0 !== 1'b1 || tvalid0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got done=%b valid=%b busy=%b required 1 0 0", done0, tvalid0, busy0);
    end
    @(negedge clk); #1;
    n_chk++;
    if (done0 !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b required 0", done0); end
  endtask

  task automatic test_backpressure();
    int cnt;
    bit seen;
    cnt = 0; seen = 0;
    push_frame(4, 2, 2'd0);
    @(posedge clk); #1 en0 = 1'b1; tready = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1 en0 = 1'b0; tready = ~tready;
      @(negedge clk); #1;
      if (tvalid0 === 1'b1) cnt++;
      if (done0 === 1'b1) seen = 1;
    end
    tready = 1'b1;
    n_chk++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: got no frame_done required frame_done"); end
    n_chk++;
    if (cnt != 16) begin n_fail++; $display("FAIL bp_cycles: got %0d valid cycles required 16", cnt); end
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_beats: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int gaps;
    bit started, ok;
    gaps = 0; started = 0; ok = 0;
    do_reset();
    hsize = 16'd3; vsize = 16'd2; pattern = 2'd3;
    push_frame(3, 2, 2'd3);
    push_frame(3, 2, 2'd3);
    @(posedge clk); #1 en0 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() <= 5) en0 = 1'b0;
      @(negedge clk); #1;
      if (tvalid0 === 1'b1) started = 1;
      else if (started && exp_q.size() != 0) gaps++;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    en0 = 1'b0;
    n_chk++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: got %0d pending required 0", exp_q.size()); end
    n_chk++;
    if (gaps != 0) begin n_fail++; $display("FAIL b2b_continuous: got %0d idle cycles required 0", gaps); end
    @(posedge clk); @(negedge clk); #1;
    n_chk++;
    if (done0 !== 1'b1 || tvalid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got done=%b valid=%b required 1 0", done0, tvalid0);
    end
  endtask

  task automatic test_gap();
    int zeros, gaps_seen, busy_bad;
    bit in_gap, idle;
    zeros = 0; gaps_seen = 0; busy_bad = 0; in_gap = 0; idle = 0;
    hsize = 16'd2; vsize = 16'd1; pattern = 2'd0; tready = 1'b1;
    @(posedge clk); #1 en5 = 1'b1;
    for (int i = 0; i < 80 && gaps_seen < 2; i++) begin
      @(negedge clk); #1;
      if (in_gap) begin
        if (tvalid5 !== 1'b1) begin
          zeros++;
          if (busy5 !== 1'b1) busy_bad++;
        end else begin
          in_gap = 0;
          gaps_seen++;
          n_chk++;
          if (zeros != 5) begin n_fail++; $display("FAIL gap_len: got %0d idle cycles required 5", zeros); end
        end
      end else if (tvalid5 === 1'b1 && tlast5 === 1'b1) begin
        in_gap = 1;
        zeros = 0;
      end
    end
    en5 = 1'b0;
    n_chk++;
    if (gaps_seen != 2) begin n_fail++; $display("FAIL gap_timeout: got %0d gaps required 2", gaps_seen); end
    n_chk++;
    if (busy_bad != 0) begin n_fail++; $display("FAIL gap_busy: got %0d non-busy gap cycles required 0", busy_bad); end
    for (int i = 0; i < 30 && !idle; i++) begin
      @(negedge clk); #1;
      if (busy5 === 1'b0) idle = 1;
    end
    n_chk++;
    if (idle !== 1'b1 || tvalid5 !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_to_idle: got busy=%b valid=%b required 0 0", busy5, tvalid5);
    end
  endtask

  task automatic test_zero_size();
    int bad;
    for (int k = 0; k < 2; k++) begin
      bad = 0;
      hsize = k == 0 ? 16'd0 : 16'd4;
      vsize = k == 0 ? 16'd2 : 16'd0;
      @(posedge clk); #1 en0 = 1'b1;
      repeat (10) begin
        @(negedge clk); #1;
        if (tvalid0 !== 1'b0 || busy0 !== 1'b0) bad++;
      end
      en0 = 1'b0;
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL zero_size_%0d: got %0d active cycles required 0", k, bad); end
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    ok = 0;
    hsize = 16'd4; vsize = 16'd2; pattern = 2'd0;
    push_frame(4, 2, 2'd0);
    @(posedge clk); #1 en0 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() <= 6) en0 = 1'b0;
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    en0 = 1'b0;
    n_chk++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL drop_drain: got %0d pending required 0", exp_q.size()); end
    repeat (3) @(negedge clk); #1;
    n_chk++;
    if (tvalid0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_idle: got valid=%b busy=%b required 0 0", tvalid0, busy0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ok = 0;
    hsize = 16'd4; vsize = 16'd2; pattern = 2'd0;
    push_frame(4, 2, 2'd0);
    pulse_en0();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() <= 2) begin ok = 1; break; end
    end
    n_chk++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_reach_beat5: got %0d pending required 2", exp_q.size()); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    n_chk++;
    if (tvalid0 !== 1'b0 || busy0 !== 1'b0 || tuser0 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b busy=%b tuser=%b required 0 0 0", tvalid0, busy0, tuser0);
    end
    exp_q.delete();
    exp_fidx = 16'd0;
    @(posedge clk); #1 rst_n = 1'b1;
    push_frame(4, 2, 2'd0);
    pulse_en0();
    wait_drain(40, ok);
    n_chk++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL restart_drain: got %0d pending required 0", exp_q.size()); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_patterns();
    int tbl[4][3] = '{'{32, 16, 2}, '{2, 3, 1}, '{1, 3, 0}, '{1, 1, 0}};
    bit ok;
    for (int k = 0; k < 4; k++) begin
      ok = 0;
      hsize = 16'(tbl[k][0]); vsize = 16'(tbl[k][1]); pattern = 2'(tbl[k][2]);
      push_frame(tbl[k][0], tbl[k][1], 2'(tbl[k][2]));
      pulse_en0();
      for (int i = 0; i < 3000; i++) begin
        @(posedge clk); #1 tready = 1'($urandom_range(0, 1));
        @(negedge clk); #1;
        if (exp_q.size() == 0) begin ok = 1; break; end
      end
      tready = 1'b1;
      n_chk++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL pattern_%0d_drain: got %0d pending required 0", k, exp_q.size()); end
      repeat (4) @(posedge clk);
    end
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_gap();
    test_zero_size();
    test_enable_drop();
    test_reset_mid();
    test_patterns();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axivideo_gen.md
# axivideo_gen

AXI4-Stream video frame source. Emits complete frames of a programmed width × height. Marks the first pixel of each frame with tuser and the last pixel of each line with tlast. Fills pixels with a selectable test pattern and honours downstream backpressure. Sits at the head of a video pipeline, as bench stimulus or on-chip pattern source, and drives stream consumers and size monitors.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- FRAME_GAP, 0, idle cycles (tvalid low) inserted between consecutive frames; range 0–65535.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- enable  input  1  level; high requests continuous frame generation.
- hsize  input  16  pixels per line; sampled at frame start.
- vsize  input  16  lines per frame; sampled at frame start.
- pattern  input  2  pattern select; sampled at frame start.
- m_axis_video_tuser  output  1  start of frame; high on pixel (0,0) only.
- m_axis_video_tlast  output  1  end of line; high on pixel x = hsize-1.
- m_axis_video_tvalid  output  1  beat valid.
- m_axis_video_tdata  output  DATA_WIDTH  pixel value.
- m_axis_video_tready  input  1  downstream ready.
- busy  output  1  high in RUN or GAP.
- frame_done  output  1  one-cycle pulse after the final beat of a frame is accepted.

## Operation
- States: IDLE, RUN, GAP.
- IDLE: when enable=1 and hsize≠0 and vsize≠0, latch hsize/vsize/pattern, clear x and y, and go to RUN.
- IDLE: zero hsize or vsize means stay in IDLE; no beats are emitted.
- RUN: presents pixel (x,y). A beat is accepted when tvalid & tready.
  - On accept, x increments.
  - When x = hsize-1, x clears and y increments.
  - Accept of (hsize-1, vsize-1) ends the frame.
- End of frame:
  - frame_done pulses.
  - If FRAME_GAP>0, go to GAP.
  - Otherwise, with enable=1, re-latch inputs and start the next frame directly; with enable=0, go to IDLE.
- GAP: counts FRAME_GAP cycles with tvalid=0. Then applies the same enable/size check as IDLE, either starting a frame or going to IDLE.
- enable low mid-frame does not truncate the frame. The current frame completes, then the block idles.
- Input changes mid-frame have no effect until the next frame start.
- Patterns (x,y are 16-bit counters; results are truncated/zero-extended to DATA_WIDTH):
  - 0: horizontal ramp, x.
  - 1: vertical ramp, y.
  - 2: checker, all-ones if x[3]^y[3], else 0.
  - 3: frame index, see Configuration.
- Frame index: 16-bit counter. It increments on every frame_done and wraps 65535→0.

## Timing
- Reset (rst_n=0 at a clock edge) takes effect at that edge, including mid-frame.
  - Values after reset: tvalid=0, tuser=0, tlast=0, tdata=0, busy=0, frame_done=0, state IDLE, x=y=0, frame index 0.
- All outputs are registered.
- enable sampled high in IDLE at edge N gives tvalid=1 with pixel (0,0) after edge N+1.
- AXI rule: once tvalid=1, tdata/tuser/tlast hold stable until accepted. tvalid never drops without an accept, except on reset.
- With tready held high, one beat is accepted per cycle. A frame takes exactly hsize·vsize cycles.
- Back-to-back (FRAME_GAP=0, enable=1): tvalid stays high across the frame boundary. The beat after the final tlast is the next frame's tuser beat.
- frame_done is high in the cycle following the final accept.
- busy falls in the same cycle the state returns to IDLE.
- FRAME_GAP=G: exactly G cycles with tvalid=0 between the final accept and the next tvalid=1.
- hsize=1: every beat has tlast=1.
- vsize=1: a single line; tuser and the first tlast can coincide when hsize=1.

## Configuration
- Macro: AXIVIDEO_GEN_FRAMEIDX_EN.
- Defined: frame index counter present; pattern 3 outputs the frame index truncated to DATA_WIDTH, constant for the whole frame.
- Undefined: counter omitted; pattern 3 behaves identically to pattern 0.

## Test plan
- hsize=4, vsize=2, pattern 0, tready=1, enable pulsed for one cycle:
  - Exactly 8 beats with tdata 0,1,2,3,0,1,2,3.
  - tuser on beat 0 only; tlast on beats 3 and 7.
  - frame_done one cycle after beat 7; then IDLE.
- Same frame with tready toggling every other cycle:
  - Identical beat sequence; tdata/tuser/tlast stable while tvalid=1 and tready=0.
  - Total of 16 cycles from first tvalid.
- enable held high, FRAME_GAP=0, hsize=3, vsize=2:
  - Continuous tvalid; tuser every 6 beats.
  - With the macro defined and pattern 3, tdata = 0 for frame 0 and 1 for frame 1.
- FRAME_GAP=5, enable high: exactly 5 tvalid=0 cycles between frames. hsize=0 with enable=1: no beats, busy=0.
- Mid-frame events:
  - enable dropped at beat 2 of a 4×2 frame: all 8 beats still emitted, then idle.
  - rst_n=0 at beat 5: tvalid=0 next cycle.
  - Restart after reset: begins at pixel (0,0) with tuser.
- pattern 2, hsize=32, vsize=16, DATA_WIDTH=8: tdata=0xFF exactly where x[3]^y[3]=1, else 0x00.
